// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue/writeback slice.
// Opcodes, FSM state encoding and default widths.
package alu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int OP_W_DEF   = 3;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_DEC  = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_NOP  = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    FIRE,
    SETTLE,
    RESP
  } state_e;

  function automatic logic is_alu_op(input logic [2:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL,
      OP_DEC, OP_CLR, OP_XOR: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic sets_z(input logic [2:0] op);
    return (op == OP_DEC) || (op == OP_CLR);
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Request/response handshake bundle for alu_issue.
// master = requester side, slave = alu_issue.
interface alu_issue_if
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) ();

  logic              req_valid;
  logic              req_ready;
  logic [OP_W-1:0]   req_op;
  logic [DATA_W-1:0] req_src;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_z;

  modport master (
    output req_valid, req_op, req_src, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_z
  );

  modport slave (
    input  req_valid, req_op, req_src, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_z
  );

endinterface

// File: rtl/alu_issue_settle_timer.sv
// Loadable down-counter timing how long alu_op is held.
// done_o is high while the count equals 1.
module alu_settle_timer #(
  parameter int CNT_W    = 4,
  parameter int LOAD_VAL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = CNT_W'(LOAD_VAL);
    else if (dec_i && cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback stage in front of the 16-bit ALU; owns AC and z.
// ISSUE_PERF_CNT_EN adds perf_ops/perf_busy counters.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int OP_W       = OP_W_DEF,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_if.slave        bus,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_z,
  output logic [DATA_W-1:0] ac
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [15:0]       perf_ops,
  output logic [15:0]       perf_busy
`endif
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ac_q, ac_d;
  logic [DATA_W-1:0] src_q, src_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic              z_q, z_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              tmr_load, tmr_dec, tmr_done;

  alu_settle_timer #(
    .CNT_W    (4),
    .LOAD_VAL (SETTLE_CYC)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (tmr_load),
    .dec_i  (tmr_dec),
    .done_o (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    ac_d        = ac_q;
    z_d         = z_q;
    op_d        = op_q;
    src_d       = src_q;
    alu_op_d    = alu_op_q;
    rsp_valid_d = rsp_valid_q;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d  = bus.req_op;
          src_d = bus.req_src;
          unique case (1'b1)
            is_alu_op(bus.req_op): state_d = ARM;
            bus.req_op == OP_LOAD: begin
              ac_d        = bus.req_src;
              rsp_valid_d = 1'b1;
              state_d     = RESP;
            end
            default: begin
              rsp_valid_d = 1'b1;
              state_d     = RESP;
            end
          endcase
        end
      end
      // alu_op is 0 through ARM so FIRE gives the ALU a fresh edge
      ARM: begin
        alu_op_d = op_q;
        state_d  = FIRE;
      end
      FIRE: begin
        tmr_load = 1'b1;
        state_d  = SETTLE;
      end
      SETTLE: begin
        tmr_dec = 1'b1;
        if (tmr_done) begin
          ac_d = alu_out;
          if (sets_z(op_q)) z_d = alu_z;
          alu_op_d    = '0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ac_q        <= '0;
      z_q         <= 1'b0;
      op_q        <= '0;
      src_q       <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ac_q        <= ac_d;
      z_q         <= z_d;
      op_q        <= op_d;
      src_q       <= src_d;
      alu_op_q    <= alu_op_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = ac_q;
  assign bus.rsp_z     = z_q;
  assign alu_in1       = ac_q;
  assign alu_in2       = src_q;
  assign alu_op        = alu_op_q;
  assign ac            = ac_q;

`ifdef ISSUE_PERF_CNT_EN
  logic [15:0] perf_ops_q, perf_busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops_q  <= '0;
      perf_busy_q <= '0;
    end else begin
      if (state_q == RESP && bus.rsp_ready)
        perf_ops_q <= perf_ops_q + 16'd1;
      if (state_q != IDLE && perf_busy_q != 16'hFFFF)
        perf_busy_q <= perf_busy_q + 16'd1;
    end
  end

  assign perf_ops  = perf_ops_q;
  assign perf_busy = perf_busy_q;
`endif

endmodule
